// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared constants for the EX->MEM pipeline register: holding-FSM state codes
// and the layout of the packed payload vector (MSB..LSB: pc|zero|alu|rd2|ctrl|rd).
package ex_mem_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  function automatic int unsigned payload_w(input int unsigned pc_w, input int unsigned data_w,
                                            input int unsigned ctrl_w, input int unsigned reg_w);
    return pc_w + 1 + 2 * data_w + ctrl_w + reg_w;
  endfunction

  function automatic int unsigned off_ctrl(input int unsigned reg_w);
    return reg_w;
  endfunction

  function automatic int unsigned off_rd2(input int unsigned ctrl_w, input int unsigned reg_w);
    return ctrl_w + reg_w;
  endfunction

  function automatic int unsigned off_alu(input int unsigned data_w, input int unsigned ctrl_w,
                                          input int unsigned reg_w);
    return data_w + ctrl_w + reg_w;
  endfunction

  function automatic int unsigned off_zero(input int unsigned data_w, input int unsigned ctrl_w,
                                           input int unsigned reg_w);
    return 2 * data_w + ctrl_w + reg_w;
  endfunction

  function automatic int unsigned off_pc(input int unsigned data_w, input int unsigned ctrl_w,
                                         input int unsigned reg_w);
    return 2 * data_w + ctrl_w + reg_w + 1;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// Valid/ready beat bus carrying one EX->MEM payload; master drives the beat, slave returns ready.
interface ex_mem_pipe_reg_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned REG_W  = 5
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc_next;
  logic              zero;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] rd2;
  logic [CTRL_W-1:0] ctrl;
  logic [REG_W-1:0]  rd_addr;

  modport master (output valid, pc_next, zero, alu_result, rd2, ctrl, rd_addr, input ready);
  modport slave  (input valid, pc_next, zero, alu_result, rd2, ctrl, rd_addr, output ready);
endinterface

// File: rtl/ex_mem_pipe_reg_pipe_skid_buf.sv
// Generic valid/ready holding register: main entry plus optional skid entry, with flush.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, issue;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign accept      = in_valid_i && in_ready_o;
  assign issue       = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush only empties the FSM; payload flops deliberately keep stale data.
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_BUSY;
          main_d  = in_data_i;
        end
        ST_BUSY: begin
          if (accept && issue) begin
            main_d = in_data_i;
          end else if (accept && SKID_EN) begin
            state_d = ST_FULL;
            skid_d  = in_data_i;
          end else if (issue) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (issue) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      // Ready is taken from next state so it is a flop yet tracks FULL with no extra lag.
      logic rdy_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b1;
        else        rdy_q <= (state_d != ST_FULL);
      end
      assign in_ready_o = rdy_q;
    end else begin : g_comb
      assign in_ready_o = !out_valid_o || out_ready_i;
    end
  endgenerate

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register: packs the EX beat, buffers it with valid/ready flow
// control, and counts cycles in which MEM stalls a held beat.
module ex_mem_pipe_reg
  import ex_mem_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned REG_W   = 5,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  ex_mem_pipe_reg_if.slave   ex,
  ex_mem_pipe_reg_if.master  mem,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned PW     = payload_w(PC_W, DATA_W, CTRL_W, REG_W);
  localparam int unsigned O_CTRL = off_ctrl(REG_W);
  localparam int unsigned O_RD2  = off_rd2(CTRL_W, REG_W);
  localparam int unsigned O_ALU  = off_alu(DATA_W, CTRL_W, REG_W);
  localparam int unsigned O_ZERO = off_zero(DATA_W, CTRL_W, REG_W);
  localparam int unsigned O_PC   = off_pc(DATA_W, CTRL_W, REG_W);

  logic [PW-1:0]    in_data, out_data;
  logic             ex_ready_w, mem_valid_w;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign in_data = {ex.pc_next, ex.zero, ex.alu_result, ex.rd2, ex.ctrl, ex.rd_addr};

  pipe_skid_buf #(
    .W       (PW),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (ex.valid),
    .in_ready_o  (ex_ready_w),
    .in_data_i   (in_data),
    .out_valid_o (mem_valid_w),
    .out_ready_i (mem.ready),
    .out_data_o  (out_data)
  );

  assign ex.ready       = ex_ready_w;
  assign mem.valid      = mem_valid_w;
  assign mem.rd_addr    = out_data[REG_W-1:0];
  assign mem.ctrl       = out_data[O_CTRL +: CTRL_W];
  assign mem.rd2        = out_data[O_RD2 +: DATA_W];
  assign mem.alu_result = out_data[O_ALU +: DATA_W];
  assign mem.zero       = out_data[O_ZERO];
  assign mem.pc_next    = out_data[O_PC +: PC_W];

  // Saturating; flush does not clear it.
  always_comb begin
    stall_d = stall_q;
    if (mem_valid_w && !mem.ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: skid instance (A, 16-bit counter) and single-register
// instance (B, 4-bit counter) checked against queue-based models every cycle.
module tb_ex_mem_pipe_reg;

  localparam int PW = 32 + 1 + 32 + 32 + 8 + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flA = 1'b0, flB = 1'b0;
  logic [15:0] stA;
  logic [3:0]  stB;

  always #5 clk = ~clk;

  ex_mem_pipe_reg_if exA ();
  ex_mem_pipe_reg_if memA ();
  ex_mem_pipe_reg_if exB ();
  ex_mem_pipe_reg_if memB ();

  ex_mem_pipe_reg #(.SKID_EN(1'b1), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .flush(flA), .ex(exA), .mem(memA), .stall_cnt(stA));
  ex_mem_pipe_reg #(.SKID_EN(1'b0), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .flush(flB), .ex(exB), .mem(memB), .stall_cnt(stB));

  logic [PW-1:0] inA, inB, outA, outB;
  assign inA  = {exA.pc_next, exA.zero, exA.alu_result, exA.rd2, exA.ctrl, exA.rd_addr};
  assign inB  = {exB.pc_next, exB.zero, exB.alu_result, exB.rd2, exB.ctrl, exB.rd_addr};
  assign outA = {memA.pc_next, memA.zero, memA.alu_result, memA.rd2, memA.ctrl, memA.rd_addr};
  assign outB = {memB.pc_next, memB.zero, memB.alu_result, memB.rd2, memB.ctrl, memB.rd_addr};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance holds an ordered list of beats; head is what MEM sees.
  logic [PW-1:0] qA[$], qB[$];
  int unsigned scA = 0, scB = 0;
  bit accA = 0, accB = 0;

  always @(posedge clk or negedge rst_n) begin
    bit rdy, iss, acc;
    if (!rst_n) begin
      qA.delete(); qB.delete();
      scA = 0; scB = 0; accA = 0; accB = 0;
    end else begin
      rdy = (qA.size() < 2);
      iss = (qA.size() > 0) && memA.ready;
      acc = exA.valid && rdy;
      if (qA.size() > 0 && !memA.ready && scA < 65535) scA++;
      if (flA) qA.delete();
      else begin
        if (iss) void'(qA.pop_front());
        if (acc) qA.push_back(inA);
      end
      accA = acc && !flA;

      rdy = (qB.size() == 0) || memB.ready;
      iss = (qB.size() > 0) && memB.ready;
      acc = exB.valid && rdy;
      if (qB.size() > 0 && !memB.ready && scB < 15) scB++;
      if (flB) qB.delete();
      else begin
        if (iss) void'(qB.pop_front());
        if (acc) qB.push_back(inB);
      end
      accB = acc && !flB;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("A_ready", 128'(exA.ready), 128'(qA.size() < 2));
      chk("A_valid", 128'(memA.valid), 128'(qA.size() != 0));
      if (qA.size() != 0) chk("A_payload", 128'(outA), 128'(qA[0]));
      chk("A_stall", 128'(stA), 128'(scA));
      chk("B_ready", 128'(exB.ready), 128'((qB.size() == 0) || memB.ready));
      chk("B_valid", 128'(memB.valid), 128'(qB.size() != 0));
      if (qB.size() != 0) chk("B_payload", 128'(outB), 128'(qB[0]));
      chk("B_stall", 128'(stB), 128'(scB));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic beatA(input bit v, input logic [31:0] alu);
    logic [31:0] r;
    r = $urandom;
    exA.valid = v; exA.pc_next = $urandom; exA.zero = r[0]; exA.alu_result = alu;
    exA.rd2 = $urandom; exA.ctrl = r[8:1]; exA.rd_addr = r[13:9];
  endtask

  task automatic beatB(input bit v, input logic [31:0] alu);
    logic [31:0] r;
    r = $urandom;
    exB.valid = v; exB.pc_next = $urandom; exB.zero = r[0]; exB.alu_result = alu;
    exB.rd2 = $urandom; exB.ctrl = r[8:1]; exB.rd_addr = r[13:9];
  endtask

  initial begin
    beatA(0, 32'h0); beatB(0, 32'h0);
    memA.ready = 1'b1; memB.ready = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;

    // Streaming on A
    beatA(1, 32'h10); cyc();
    chk("stream_0x10", 128'(memA.alu_result), 128'h10);
    beatA(1, 32'h20); cyc();
    chk("stream_0x20", 128'(memA.alu_result), 128'h20);
    beatA(1, 32'h30); cyc();
    chk("stream_0x30", 128'(memA.alu_result), 128'h30);
    chk("stream_valid", 128'(memA.valid), 128'(1));
    beatA(0, 32'h0); cyc();
    chk("stream_drained", 128'(memA.valid), 128'(0));
    chk("stream_stall", 128'(stA), 128'(0));

    // Back-pressure on A
    memA.ready = 1'b0;
    beatA(1, 32'h10); cyc();
    chk("bp_ready_busy", 128'(exA.ready), 128'(1));
    beatA(1, 32'h20); cyc();
    chk("bp_ready_full", 128'(exA.ready), 128'(0));
    chk("bp_hold", 128'(memA.alu_result), 128'h10);
    chk("bp_stall1", 128'(stA), 128'(1));
    beatA(0, 32'h0); cyc();
    chk("bp_stall2", 128'(stA), 128'(2));
    chk("bp_hold2", 128'(memA.alu_result), 128'h10);
    memA.ready = 1'b1; cyc();
    chk("bp_issue2", 128'(memA.alu_result), 128'h20);
    chk("bp_ready_back", 128'(exA.ready), 128'(1));
    chk("bp_stall_kept", 128'(stA), 128'(2));
    cyc();
    chk("bp_empty", 128'(memA.valid), 128'(0));

    // Asynchronous reset mid-clock with a beat held
    memA.ready = 1'b0;
    beatA(1, 32'h99); cyc();
    beatA(0, 32'h0); cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 128'(memA.valid), 128'(0));
    chk("rst_ready", 128'(exA.ready), 128'(1));
    chk("rst_alu", 128'(memA.alu_result), 128'(0));
    chk("rst_stall", 128'(stA), 128'(0));
    cyc();
    rst_n = 1'b1;

    // Flush while FULL with an incoming beat
    beatA(1, 32'h10); cyc();
    beatA(1, 32'h20); cyc();
    beatA(1, 32'h40); flA = 1'b1; cyc();
    chk("flush_valid", 128'(memA.valid), 128'(0));
    chk("flush_ready", 128'(exA.ready), 128'(1));
    chk("flush_stall", 128'(stA), 128'(2));
    flA = 1'b0; beatA(0, 32'h0); memA.ready = 1'b1; cyc();
    chk("flush_no_0x40", 128'(memA.valid), 128'(0));
    chk("flush_stall_kept", 128'(stA), 128'(2));

    // Single-register B: combinational ready and counter saturation
    memB.ready = 1'b0;
    beatB(1, 32'h55); cyc();
    beatB(0, 32'h0);
    #1;
    chk("B_ready_same_cycle", 128'(exB.ready), 128'(0));
    repeat (20) cyc();
    chk("B_sat", 128'(stB), 128'd15);
    chk("B_hold", 128'(memB.alu_result), 128'h55);
    memB.ready = 1'b1; beatB(1, 32'h66);
    #1;
    chk("B_ready_comb", 128'(exB.ready), 128'(1));
    cyc();
    chk("B_b2b_0x66", 128'(memB.alu_result), 128'h66);
    beatB(1, 32'h77); cyc();
    chk("B_b2b_0x77", 128'(memB.alu_result), 128'h77);
    beatB(0, 32'h0); cyc();
    chk("B_drained", 128'(memB.valid), 128'(0));
    chk("B_sat_kept", 128'(stB), 128'd15);

    // Randomised traffic; EX keeps a beat stable until it is accepted
    for (int i = 0; i < 3000; i++) begin
      if (!exA.valid || accA) beatA($urandom_range(0, 3) != 0, $urandom);
      if (!exB.valid || accB) beatB($urandom_range(0, 3) != 0, $urandom);
      memA.ready = ($urandom_range(0, 3) != 0);
      memB.ready = ($urandom_range(0, 3) != 0);
      flA = ($urandom_range(0, 31) == 0);
      flB = ($urandom_range(0, 31) == 0);
      cyc();
    end
    flA = 1'b0; flB = 1'b0;
    beatA(0, 32'h0); beatB(0, 32'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
